// File: rtl/ring_osc_pkg.sv
// Shared types and helpers for the ring-oscillator frequency meter:
// controller states, width helper, LUT4 evaluation and Gray/binary conversion.
package ring_osc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Channel-index width; a single-channel meter still gets a 1-bit index.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Behaviour of one SB_LUT4: output is INIT bit addressed by {I3,I2,I1,I0}.
  function automatic logic lut4(input logic [15:0] init, input logic [3:0] idx);
    return init[idx];
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ring_osc_if.sv
// Request/result port of the ring-oscillator meter, plus scope taps,
// the simulation oscillator sources and the controller state for observation.
interface ring_osc_if #(
  parameter int CHANNELS = 4,
  parameter int COUNT_W  = 16
);
  import ring_osc_pkg::*;

  localparam int CH_W = ch_w(CHANNELS);

  // start is a request sampled only while the controller is in IDLE; it is
  // never queued. result_valid rises with a new result and result/result_chan
  // hold stable until a clk edge samples result_ready high, which completes
  // the transfer; result_ready may be tied high.
  logic                start;
  logic [CH_W-1:0]     chan_sel;
  logic                busy;
  logic [COUNT_W-1:0]  result;
  logic [CH_W-1:0]     result_chan;
  logic                result_valid;
  logic                result_ready;
  logic [CHANNELS-1:0] osc_tap;
  logic [CHANNELS-1:0] ring_src;
  state_t              state;

  modport master (
    output start, chan_sel, result_ready, ring_src,
    input  busy, result, result_chan, result_valid, osc_tap, state
  );

  modport slave (
    input  start, chan_sel, result_ready, ring_src,
    output busy, result, result_chan, result_valid, osc_tap, state
  );

endinterface

// File: rtl/ring_osc_channel.sv
// One enable-gated ring oscillator with its ring-clocked prescaler and Gray
// edge counter. Counters clear only on rst_n so measurements are differential.
module ring_osc_channel
  import ring_osc_pkg::*;
#(
  parameter int                 STAGES   = 1,
  parameter int                 PRESCALE = 4,
  parameter int                 COUNT_W  = 16,
  parameter bit                 SIM_RING = 1'b1,
  parameter logic [COUNT_W-1:0] CNT_INIT = '0
) (
  input  logic               rst_n,
  input  logic               en,
  input  logic               sim_src,
  output logic               tap,
  output logic [COUNT_W-1:0] gray
);

  logic               ring_out;
  logic [PRESCALE-1:0] pre;
  logic [COUNT_W-1:0] cnt;
  logic [COUNT_W-1:0] cnt_nxt;

  generate
    if (SIM_RING) begin : g_sim
      // Behavioural stand-in: a disabled ring sits low exactly like the LUT ring.
      assign ring_out = en & sim_src;
    end else begin : g_lut
      logic [STAGES-1:0] stage;
      // Stage 0 is the enable gate (I1=en, I0=feedback): en & ~ring_out.
      assign stage[0] = lut4(16'h4444, {2'b00, en, ring_out});
      for (genvar k = 1; k < STAGES; k++) begin : g_inv
        assign stage[k] = lut4(16'h5555, {3'b000, stage[k-1]});
      end
      assign ring_out = stage[STAGES-1];
    end
  endgenerate

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge ring_out or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      cnt  <= CNT_INIT;
      gray <= COUNT_W'(bin2gray(32'(CNT_INIT)));
    end else begin
      pre <= pre + 1'b1;
      if (&pre) begin
        cnt  <= cnt_nxt;
        gray <= COUNT_W'(bin2gray(32'(cnt_nxt)));
      end
    end
  end

  assign tap = pre[PRESCALE-1];

endmodule

// File: rtl/ring_osc_meter.sv
// Multi-channel ring-oscillator frequency meter: enables one ring at a time,
// snapshots its synchronized count across a fixed gate window, reports the delta.
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int                          CHANNELS      = 4,
  parameter int                          STAGES        = 1,
  parameter int                          PRESCALE      = 4,
  parameter int                          COUNT_W       = 16,
  parameter int                          SETTLE_CYCLES = 64,
  parameter int                          GATE_CYCLES   = 12000,
  parameter bit                          SIM_RING      = 1'b1,
  parameter logic [CHANNELS*COUNT_W-1:0] CNT_INIT      = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  ring_osc_if.slave bus
);

  localparam int CH_W    = ch_w(CHANNELS);
  localparam int CYC_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int CNT_W   = $clog2(CYC_MAX + 1);

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] tap;
  logic [COUNT_W-1:0]  gray  [CHANNELS];
  logic [COUNT_W-1:0]  sync1 [CHANNELS];
  logic [COUNT_W-1:0]  sync2 [CHANNELS];
  logic [COUNT_W-1:0]  snap  [CHANNELS];

  state_t             state, state_nxt;
  logic [CH_W-1:0]    chan;
  logic [CNT_W-1:0]   cnt;
  logic [COUNT_W-1:0] snap0;
  logic [COUNT_W-1:0] result;
  logic [CH_W-1:0]    result_chan;
  logic               result_valid;
  logic               start_ok;
  logic               settle_done;
  logic               gate_done;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      ring_osc_channel #(
        .STAGES   (STAGES),
        .PRESCALE (PRESCALE),
        .COUNT_W  (COUNT_W),
        .SIM_RING (SIM_RING),
        .CNT_INIT (CNT_INIT[i*COUNT_W +: COUNT_W])
      ) u_ch (
        .rst_n   (rst_n),
        .en      (en[i]),
        .sim_src (bus.ring_src[i]),
        .tap     (tap[i]),
        .gray    (gray[i])
      );
    end
  endgenerate

  // Gray code changes one bit per count, so a 2-FF capture is off by at most one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync1[i] <= '0;
        sync2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync1[i] <= gray[i];
        sync2[i] <= sync1[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      snap[i] = COUNT_W'(gray2bin(32'(sync2[i])));
    end
  end

  assign start_ok    = bus.start && (int'(bus.chan_sel) < CHANNELS);
  assign settle_done = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign gate_done   = (cnt == CNT_W'(GATE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok)         state_nxt = SETTLE;
      SETTLE:  if (settle_done)      state_nxt = GATE;
      GATE:    if (gate_done)        state_nxt = REPORT;
      REPORT:  if (bus.result_ready) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= '0;
      chan         <= '0;
      cnt          <= '0;
      snap0        <= '0;
      result       <= '0;
      result_chan  <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          chan <= bus.chan_sel;
          en   <= CHANNELS'(1) << bus.chan_sel;
          cnt  <= '0;
        end
        SETTLE: if (settle_done) begin
          snap0 <= snap[chan];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        GATE: if (gate_done) begin
          // Modular difference keeps the count right across counter wrap.
          result       <= snap[chan] - snap0;
          result_chan  <= chan;
          en           <= '0;
          result_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        REPORT: if (bus.result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.result       = result;
  assign bus.result_chan  = result_chan;
  assign bus.result_valid = result_valid;
  assign bus.osc_tap      = tap;
  assign bus.state        = state;

endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Multi-channel ring-oscillator frequency meter for iCE40. Each channel is an enable-gated SB_LUT4 inverter ring with an on-ring prescaler and Gray-coded edge counter. A single `clk`-domain controller runs one channel at a time for a fixed gate window and returns the prescaled edge count through a valid/ready result port. The block is the measurement core behind LED/aux debug outputs and sits directly under `top`.

## Interface
- `CHANNELS`, 4: number of independent rings, ≥1.
- `STAGES`, 1: inverting LUTs per ring, odd, ≥1.
- `PRESCALE`, 4: ring-domain divider exponent; counted edge rate = f_ring / 2^PRESCALE.
- `COUNT_W`, 16: Gray counter and result width.
- `SETTLE_CYCLES`, 64: `clk` cycles between ring enable and the first snapshot, ≥4.
- `GATE_CYCLES`, 12000: `clk` cycles between snapshots, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `start` in 1: measurement request, sampled in IDLE only.
- `chan_sel` in clog2(CHANNELS): channel to measure; captured with `start`.
- `busy` out 1: high in every state except IDLE.
- `result` out COUNT_W: prescaled edge count.
- `result_chan` out clog2(CHANNELS): channel that produced `result`.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.
- `osc_tap` out CHANNELS: prescaler MSB per ring, used as a scope/aux output.

## Operation
- Ring i: `chain_in = en[i] ? ~ring_out : 0` through STAGES LUTs (LUT_INIT inverter/buffer mix, net odd inversion). `en` is one-hot or zero. A disabled ring holds low and produces no edges.
- Ring domain, clocked by ring output:
  - PRESCALE-bit binary prescaler.
  - On prescaler wrap, a COUNT_W Gray counter increments.
  - Both are asynchronously cleared by `rst_n` only. They are never cleared on disable, because measurement is difference-based.
- `clk` domain: a 2-FF synchronizer per channel on the Gray value, followed by Gray→binary conversion (`snap`).
- FSM states (ring_osc_pkg enum): IDLE, SETTLE, GATE, REPORT.
  - IDLE: `start`=1 → capture `chan_sel`, set `en[chan]`, zero cycle counter → SETTLE. `chan_sel` ≥ CHANNELS → start ignored, stay IDLE.
  - SETTLE: count SETTLE_CYCLES. On the last cycle, `snap0 <= snap[chan]` → GATE.
  - GATE: count GATE_CYCLES. On the last cycle, `result <= snap[chan] − snap0` (mod 2^COUNT_W), `result_chan <= chan`, `en <= 0`, `result_valid <= 1` → REPORT.
  - REPORT: hold `result`, `result_chan`, `result_valid` stable until `result_ready`=1 is sampled. Then `result_valid <= 0` → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Wrap: subtraction is modular. Integrators choose GATE_CYCLES so that the true count is < 2^COUNT_W; above that, `result` aliases silently.

## Timing
- Reset values: state IDLE, `en`=0, `busy`=0, `result`=0, `result_chan`=0, `result_valid`=0. Synchronizers and ring counters are cleared.
- `start` sampled high at edge t:
  - `busy`=1 from t+1.
  - `snap0` captured at t+SETTLE_CYCLES.
  - `result_valid`=1 from t+SETTLE_CYCLES+GATE_CYCLES.
- `result_valid`∧`result_ready` at edge u → `result_valid`=0 and `busy`=0 from u+1. A new `start` is accepted at u+1 at the earliest.
- `result_ready` may be held permanently high. The minimum time in REPORT is one cycle.
- Reset mid-operation: everything is aborted immediately (async), rings are disabled, and no result is produced.
- Result accuracy: ±1 counted edge, from synchronizer sampling at both snapshots.

## Structure
- `ring_osc_pkg`: the state enum, the `CH_W = $clog2(CHANNELS)` helper convention, and Gray↔binary conversion functions.
- Sub-module `ring_osc_channel`, one instance per channel, containing:
  - the LUT ring with enable gating;
  - the prescaler;
  - the Gray counter;
  - `osc_tap`;
  - the Gray-value output.
- `ring_osc_meter` holds the synchronizers, the FSM, the snapshot/subtract datapath and the result register.
- For simulation, the SB_LUT4 ring is replaced by a behavioural oscillator with parameterised half-period.

## Test plan
- Default parameters. Sim ring ch0 period 4.8 ns, `clk` 83.33 ns. `start` with `chan_sel`=0 → `result_valid` exactly SETTLE+GATE cycles after `start`; `result` = 13020±1 (12000×83.33/4.8/16).
- Repeat on ch2 with a 9.6 ns period → `result` 6510±1, `result_chan`=2. Rings ch0, ch1 and ch3 show no edges throughout.
- Hold `result_ready`=0 for 50 cycles, pulse `start` during REPORT → `result`/`result_valid` remain stable, no new measurement starts. Raise `result_ready` → IDLE next cycle.
- Preload ring ch1's Gray counter to 0xFFF0, measure with a 4.8 ns period → correct 13020±1 across counter wrap.
- Assert `rst_n`=0 mid-GATE → all outputs reach reset values immediately, `en`=0. After release, a fresh measurement gives the correct count.
- `chan_sel`=5 with CHANNELS=4 → ignored, `busy` stays 0. `start` pulsed on two consecutive cycles → exactly one measurement.
